// File: rtl/coherence_pkg.sv
// Shared types and constants for the two-cache snooping coherence controller.
package coherence_pkg;

  localparam int unsigned NCACHE = 2;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    RESP  = 3'd2,
    CCWB1 = 3'd3,
    CCWB2 = 3'd4,
    GRANT = 3'd5,
    MEMWB = 3'd6
  } cc_state_t;

endpackage

// File: rtl/cc_rr_arbiter.sv
// Two-way round-robin grant; the pointer only breaks ties and toggles on advance.
module cc_rr_arbiter
  import coherence_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NCACHE-1:0] req_i,
  input  logic              advance_i,
  output logic              grant_o
);

  logic rr_ptr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q <= 1'b0;
    end else if (advance_i) begin
      rr_ptr_q <= ~rr_ptr_q;
    end
  end

  // A lone requester wins outright; on contention the pointer decides.
  assign grant_o = (&req_i) ? rr_ptr_q : req_i[1];

endmodule

// File: rtl/coherence_ctrl.sv
// Bus-side coherence controller: serialises snoops between two write-back
// data caches and multiplexes their traffic onto a single-port RAM.
module coherence_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NCACHE = 2
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NCACHE-1:0]              cctrans,
  input  logic [NCACHE-1:0]              ccwrite,
  input  logic [NCACHE-1:0]              dREN,
  input  logic [NCACHE-1:0]              dWEN,
  input  logic [NCACHE-1:0][ADDR_W-1:0]  daddr,
  input  logic [NCACHE-1:0][ADDR_W-1:0]  dstore,
  output logic [NCACHE-1:0]              ccwait,
  output logic [NCACHE-1:0]              ccinv,
  output logic [NCACHE-1:0][ADDR_W-1:0]  ccsnoopaddr,
  output logic [NCACHE-1:0]              dwait,
  output logic [NCACHE-1:0][ADDR_W-1:0]  dload,
  output logic                           ramREN,
  output logic                           ramWEN,
  output logic [ADDR_W-1:0]              ramaddr,
  output logic [ADDR_W-1:0]              ramstore,
  input  logic [ADDR_W-1:0]              ramload,
  input  logic [1:0]                     ramstate
);
  import coherence_pkg::*;

  if (NCACHE != coherence_pkg::NCACHE) begin : g_ncache_check
    $error("coherence_ctrl supports exactly two caches");
  end

  cc_state_t         state_q, state_d;
  logic              owner_q, owner_d;
  logic              peer_c;
  logic              arb_grant_c;
  logic              txn_done_c;
  logic              ram_acc_c;
  logic [NCACHE-1:0] req_c;

  assign peer_c    = ~owner_q;
  assign req_c     = cctrans | dREN | dWEN;
  assign ram_acc_c = (ramstate_t'(ramstate) == RAM_ACCESS);
  assign dload     = {NCACHE{ramload}};

  cc_rr_arbiter u_arb (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_i     (req_c),
    .advance_i (txn_done_c),
    .grant_o   (arb_grant_c)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    txn_done_c  = 1'b0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    dwait       = '1;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        // A read without cctrans is held here until the miss is announced.
        if (|req_c) begin
          owner_d = arb_grant_c;
          if (cctrans[arb_grant_c]) begin
            state_d = SNOOP;
          end else if (dWEN[arb_grant_c]) begin
            state_d = MEMWB;
          end
        end
      end
      SNOOP, RESP, CCWB1, CCWB2: begin
        ccwait[peer_c]      = 1'b1;
        ccsnoopaddr[peer_c] = daddr[owner_q];
        ccinv[peer_c]       = ccwrite[owner_q] | dREN[owner_q];
        if (state_q == SNOOP) begin
          state_d = RESP;
        end else if (state_q == RESP) begin
          state_d = (cctrans[peer_c] & ccwrite[peer_c]) ? CCWB1 : GRANT;
        end else begin
          // Peer dirty-line writeback, one word per RAM access.
          ramWEN        = dWEN[peer_c];
          ramaddr       = daddr[peer_c];
          ramstore      = dstore[peer_c];
          dwait[peer_c] = ~(dWEN[peer_c] & ram_acc_c);
          if (ram_acc_c) begin
            state_d = (state_q == CCWB1) ? CCWB2 : GRANT;
          end
        end
      end
      GRANT: begin
        ccinv[owner_q] = 1'b1;
        ramREN         = dREN[owner_q];
        ramaddr        = daddr[owner_q];
        dwait[owner_q] = ~(dREN[owner_q] & ram_acc_c);
        if (!(cctrans[owner_q] | dREN[owner_q])) begin
          state_d    = IDLE;
          txn_done_c = 1'b1;
        end
      end
      MEMWB: begin
        ramWEN         = dWEN[owner_q];
        ramaddr        = daddr[owner_q];
        ramstore       = dstore[owner_q];
        dwait[owner_q] = ~(dWEN[owner_q] & ram_acc_c);
        if (!dWEN[owner_q]) begin
          state_d    = IDLE;
          txn_done_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Scoreboarded bench for coherence_ctrl: a small RAM model, two scripted
// caches, and a monitor that retires each RAM access against an expected queue.
module tb_coherence_ctrl;
  import coherence_pkg::*;

  typedef struct packed {
    logic        k;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       cctrans, ccwrite, dREN, dWEN;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       ccwait, ccinv, dwait;
  logic [1:0][31:0] ccsnoopaddr, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int  checks   = 0;
  int  failures = 0;
  sb_t sb_q[$];

  logic [31:0] ram_mem [1024];
  logic [1:0]  lat_q;
  logic        ram_en;

  always #5 CLK = ~CLK;

  coherence_ctrl #(.ADDR_W(32), .NCACHE(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .cctrans(cctrans), .ccwrite(ccwrite), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [1:0] onehot(input logic k);
    logic [1:0] v;
    v    = 2'b00;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM model: one BUSY cycle, then ACCESS, for every enabled word.
  assign ram_en   = ramREN | ramWEN;
  assign ramstate = !ram_en ? 2'(RAM_FREE) : ((lat_q == 2'd1) ? 2'(RAM_ACCESS) : 2'(RAM_BUSY));
  assign ramload  = ram_mem[ramaddr[11:2]];

  initial for (int i = 0; i < 1024; i++) ram_mem[i] = pat(32'(i * 4));

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) lat_q <= 2'd0;
    else if (!ram_en || ramstate == 2'(RAM_ACCESS)) lat_q <= 2'd0;
    else lat_q <= lat_q + 2'd1;
  end

  always @(posedge CLK) begin
    if (nRST && ramWEN && ramstate == 2'(RAM_ACCESS)) ram_mem[ramaddr[11:2]] <= ramstore;
  end

  // Monitor: each completing RAM word retires the oldest expectation.
  always @(negedge CLK) begin
    sb_t        e;
    logic [1:0] dw_exp;
    if (nRST && ram_en && ramstate == 2'(RAM_ACCESS)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_access", 32'(sb_q.size()), 1);
      end else begin
        e      = sb_q.pop_front();
        dw_exp = ~onehot(e.k);
        check("sb_txn", {ramWEN, ramaddr, (ramWEN ? ramstore : dload[e.k])}, {e.we, e.addr, e.data});
        check("sb_dwait", dwait, dw_exp);
        check("sb_excl", {ramREN, ramWEN}, {~e.we, e.we});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    cctrans = '0; ccwrite = '0; dREN = '0; dWEN = '0;
    daddr   = '0; dstore  = '0;
  endtask

  // Waits for the SNOOP cycle of owner r, checks SNOOP/RESP outputs, optionally
  // has the peer answer dirty during RESP; returns one cycle after RESP.
  task automatic wait_snoop(input logic r, input logic [31:0] a, input logic inv,
                            input logic dirty, input logic [31:0] d0);
    logic o;
    bit   seen;
    o    = ~r;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      if (ccwait != 2'b00) seen = 1'b1;
      else tick();
    end
    if (!seen) check("snoop_timeout", ccwait, onehot(o));
    check("snoop_ccwait", ccwait, onehot(o));
    check("snoop_addr", ccsnoopaddr[o], a);
    check("snoop_ccinv", ccinv, inv ? onehot(o) : 2'b00);
    check("snoop_dwait_req", dwait[r], 1);
    tick();
    if (dirty) begin
      cctrans[o] = 1'b1; ccwrite[o] = 1'b1; dWEN[o] = 1'b1;
      daddr[o]   = a;    dstore[o]  = d0;
    end
    @(negedge CLK);
    check("resp_ccwait", ccwait, onehot(o));
    tick();
  endtask

  // Cache k moves two consecutive words through RAM, then releases the bus.
  task automatic serve_words(input logic k, input logic we, input logic [31:0] a0,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic chk_grant);
    bit done;
    for (int w = 0; w < 2; w++) begin
      done     = 1'b0;
      daddr[k] = a0 + 32'(4 * w);
      dstore[k] = (w == 0) ? d0 : d1;
      if (we) dWEN[k] = 1'b1;
      else    dREN[k] = 1'b1;
      sb_q.push_back({k, we, daddr[k], dstore[k]});
      for (int c = 0; c < 30 && !done; c++) begin
        @(negedge CLK);
        if (chk_grant && w == 0 && c == 0) begin
          check("grant_ccinv", ccinv, onehot(k));
          check("grant_ccwait", ccwait[k], 0);
        end
        if (!dwait[k]) done = 1'b1;
        tick();
      end
      if (!done) check("word_timeout", dwait[k], 0);
    end
    dREN[k] = 1'b0; dWEN[k] = 1'b0; cctrans[k] = 1'b0; ccwrite[k] = 1'b0;
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b0;
    #3;
    check("rst_dwait", dwait, 2'b11);
    check("rst_ccwait", ccwait, 2'b00);
    check("rst_ccinv", ccinv, 2'b00);
    check("rst_ram_en", {ramREN, ramWEN}, 2'b00);
    check("rst_ramaddr", ramaddr, 0);
    tick(); tick();
    @(negedge CLK) nRST = 1'b1;
    tick();

    // Cache0 read miss, cache1 clean.
    cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h40;
    @(negedge CLK);
    check("t1_idle_dwait", dwait, 2'b11);
    check("t1_idle_ccwait", ccwait, 2'b00);
    tick();
    wait_snoop(1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
    serve_words(1'b0, 1'b0, 32'h40, pat(32'h40), pat(32'h44), 1'b1);
    tick();

    // Cache0 read miss, cache1 dirty: writeback then read-back of the same words.
    cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h80;
    tick();
    wait_snoop(1'b0, 32'h80, 1'b1, 1'b1, 32'hDEAD_0080);
    @(negedge CLK);
    check("t2_ccwb_ccwait", ccwait, 2'b10);
    check("t2_ccwb_wen", {ramREN, ramWEN}, 2'b01);
    tick();
    serve_words(1'b1, 1'b1, 32'h80, 32'hDEAD_0080, 32'hBEEF_0084, 1'b0);
    serve_words(1'b0, 1'b0, 32'h80, 32'hDEAD_0080, 32'hBEEF_0084, 1'b1);
    tick();

    // Cache1 write-invalidate on a clean hit; no RAM traffic.
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h100;
    tick();
    wait_snoop(1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    check("t3_grant_ccinv", ccinv, 2'b10);
    check("t3_grant_ccwait", ccwait, 2'b00);
    check("t3_no_ram", {ramREN, ramWEN}, 2'b00);
    cctrans[1] = 1'b0; ccwrite[1] = 1'b0;
    tick();
    @(negedge CLK);
    check("t3_ccinv_one_cycle", ccinv, 2'b00);
    tick();

    // Reset pulsed during the peer writeback.
    cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h400;
    tick();
    wait_snoop(1'b0, 32'h400, 1'b1, 1'b1, 32'h1234_5678);
    @(negedge CLK);
    check("t6_in_ccwb", ramWEN, 1);
    #1 nRST = 1'b0;
    #1;
    check("t6_rst_ramwen", {ramREN, ramWEN}, 2'b00);
    check("t6_rst_ccwait", ccwait, 2'b00);
    check("t6_rst_dwait", dwait, 2'b11);
    check("t6_rst_ccinv", ccinv, 2'b00);
    clear_inputs();
    tick();
    @(negedge CLK) nRST = 1'b1;
    tick();
    @(negedge CLK);
    check("t6_idle_ccwait", ccwait, 2'b00);
    check("t6_idle_dwait", dwait, 2'b11);
    check("t6_idle_ram", {ramREN, ramWEN}, 2'b00);
    tick();

    // Two contentions in a row: 0, 1, then 0 again.
    for (int round = 0; round < 2; round++) begin
      cctrans = 2'b11; dREN = 2'b11;
      daddr[0] = 32'h200 + 32'(round * 'h40);
      daddr[1] = 32'h300 + 32'(round * 'h40);
      tick();
      wait_snoop(1'b0, daddr[0], 1'b1, 1'b0, 32'h0);
      serve_words(1'b0, 1'b0, daddr[0], pat(daddr[0]), pat(daddr[0] + 32'h4), 1'b1);
      wait_snoop(1'b1, daddr[1], 1'b1, 1'b0, 32'h0);
      serve_words(1'b1, 1'b0, daddr[1], pat(daddr[1]), pat(daddr[1] + 32'h4), 1'b1);
      tick();
    end

    // Cache0 flush competing with a cache1 read miss.
    dWEN[0] = 1'b1; daddr[0] = 32'h1C0; dstore[0] = 32'hF1F1_01C0;
    cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h2C0;
    tick();
    @(negedge CLK);
    check("t5_memwb_ccwait", ccwait, 2'b00);
    check("t5_memwb_wen", {ramREN, ramWEN}, 2'b01);
    check("t5_memwb_addr", ramaddr, 32'h1C0);
    tick();
    serve_words(1'b0, 1'b1, 32'h1C0, 32'hF1F1_01C0, 32'hF2F2_01C4, 1'b0);
    wait_snoop(1'b1, 32'h2C0, 1'b1, 1'b0, 32'h0);
    serve_words(1'b1, 1'b0, 32'h2C0, pat(32'h2C0), pat(32'h2C4), 1'b1);
    tick(); tick();

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coherence_ctrl.md
Name: coherence_ctrl

Overview:
- Bus-side coherence controller and RAM arbiter for two snooping write-back data caches. It is the responder for each cache's cctrans/ccwrite requests.
- Serialises all coherent transactions: snoops the peer cache, forwards the peer's dirty writebacks to RAM, then grants the requester and routes its RAM traffic.
- Sits between the per-core data caches and the single-port RAM. The instruction path is arbitrated upstream of this block.

Parameters:
- ADDR_W, 32, address and data word width.
- NCACHE, 2, number of snooping caches; fixed at 2, elaborates an error otherwise.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- cctrans  in  2  per-cache coherent request / snoop-response valid.
- ccwrite  in  2  per-cache: write-invalidate intent (requester) or dirty-hit flag (snooper).
- dREN  in  2  per-cache RAM read request.
- dWEN  in  2  per-cache RAM write request.
- daddr  in  2x32  per-cache word address.
- dstore  in  2x32  per-cache store data.
- ccwait  out  2  per-cache: enter snoop / you are the snoopee.
- ccinv  out  2  snoopee: invalidate your copy; requester: grant.
- ccsnoopaddr  out  2x32  snoop address driven to snoopee.
- dwait  out  2  per-cache: RAM access not complete.
- dload  out  2x32  per-cache load data, a copy of ramload.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset values: state=IDLE, owner=0, rr_ptr=0. All outputs 0; dwait=2'b11.
- Reset mid-transaction aborts it; RAM enables drop asynchronously.
- Bus ownership:
  - Single owner r; the other cache is o.
  - Request condition for cache k: cctrans[k] | dREN[k] | dWEN[k].
  - In IDLE, if both caches request, rr_ptr selects the owner; rr_ptr toggles after every completed transaction.
- dwait rule: dwait[r] = ~(ramstate==ACCESS) while r's dREN or dWEN is routed to RAM; 1 otherwise.
- dload[k] = ramload at all times.
- ramREN/ramWEN are never high together. ramaddr = routed daddr.
- State machine:
  - IDLE: on a request from k, set r=k.
    - cctrans[r] → SNOOP.
    - dWEN[r] without cctrans (eviction writeback or flush) → MEMWB.
    - No action on dREN alone without cctrans; held until cctrans.
  - SNOOP, one cycle:
    - ccwait[o]=1, ccsnoopaddr[o]=daddr[r], ccinv[o]=ccwrite[r] | dREN[r].
    - Any peer copy is invalidated. No shared state.
    - → RESP.
  - RESP:
    - Hold ccwait[o], ccsnoopaddr[o], ccinv[o].
    - Sample cctrans[o] & ccwrite[o].
    - If both set (peer dirty) → CCWB1; else → GRANT.
  - CCWB1/CCWB2:
    - Route o's dWEN/daddr/dstore to RAM; dwait[o] per the dwait rule.
    - ccwait[o] stays 1 so o does not issue its own request.
    - Advance on ramstate==ACCESS; CCWB2 → GRANT.
  - GRANT:
    - ccinv[r]=1, ccwait[r]=0; route r's dREN/daddr to RAM.
    - Stay while cctrans[r] | dREN[r]. If dREN[r] is set on entry and ramstate==ACCESS, the first word completes in the same cycle.
    - → IDLE when both drop.
    - Write-invalidate completes on the first GRANT cycle (r sees ~ccwait & ccinv).
  - MEMWB:
    - Route r's dWEN; → IDLE when dWEN[r] drops.
    - A flush that asserts cctrans only while ccwait is high is ignored.
- ccwait[r] is always 0 while r owns the bus.
- A request from o during any non-IDLE state is held, never dropped, and served next.
- ramstate==ERROR is treated as BUSY and dwait stays high. No recovery.
- Minimum coherent read latency, request to first dwait low: 3 cycles (SNOOP, RESP, GRANT).

Decomposition:
- Shared package coherence_pkg:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR).
  - cc_state_t enum (IDLE, SNOOP, RESP, CCWB1, CCWB2, GRANT, MEMWB).
  - NCACHE constant.
- One sub-module, cc_rr_arbiter: 2-way round-robin grant with an advance input.
- The FSM and RAM mux stay in coherence_ctrl.

Test Plan:
- Cache0 read miss at 0x0000_0040, cache1 clean. Expect: ccwait[1]=1 for 2 cycles, ccsnoopaddr[1]=0x40, ccinv[1]=1, then ccinv[0]=1. ramREN follows 0x40 then 0x44, and dload[0] returns RAM data with dwait[0] low on ACCESS.
- Cache0 read miss at 0x80, cache1 dirty, answering ccwrite=1. Expect: ramWEN at 0x80/0x84 with cache1's dstore, dwait[1] pulses, then cache0 reads back the same two words.
- Cache1 write to a clean hit at 0x100 (cctrans=ccwrite=1, no dREN). Expect: ccinv[0]=1 and ccsnoopaddr[0]=0x100, then ccinv[1]=1 for one cycle. No RAM access.
- Both caches assert cctrans in the same cycle, twice in a row. Expect: cache0 served first, then cache1, then cache0 on the next contention. Neither is starved.
- Cache0 flush (dWEN only) at 0x1C0/0x1C4 while cache1 requests. Expect: MEMWB completes both words before cache1's SNOOP begins.
- nRST pulsed low during CCWB1. Expect: ramWEN=0, ccwait=0, dwait=2'b11 immediately; state=IDLE on release.
